// File: rtl/neuron_pkg.sv
// Shared types, default widths and the overflow-aware adder for the neuron MAC.
package neuron_pkg;

    typedef enum logic [2:0] {IDLE, ACCUM, DRAIN, BIAS, DONE} state_t;

    localparam int unsigned N_INPUTS_DEF  = 64;
    localparam int unsigned X_WIDTH_DEF   = 8;
    localparam int unsigned W_WIDTH_DEF   = 8;
    localparam int unsigned ACC_WIDTH_DEF = 32;
    // Adds are evaluated at this width, then folded back to the accumulator width
    localparam int unsigned WIDE          = 64;

    typedef struct packed {
        logic                   ovf;
        logic signed [WIDE-1:0] sum;
    } add_res_t;

    // Signed add of two sign-extended operands, checked against a width-bit range
    function automatic add_res_t sat_add(input logic signed [WIDE-1:0] a,
                                         input logic signed [WIDE-1:0] b,
                                         input int unsigned            width,
                                         input logic                   sat);
        add_res_t               r;
        logic signed [WIDE-1:0] full;
        logic signed [WIDE-1:0] max_v;
        logic signed [WIDE-1:0] min_v;
        logic signed [WIDE-1:0] wrapped;
        int unsigned            sh;
        sh      = WIDE - width;
        full    = a + b;
        max_v   = $signed((WIDE'(1) << (width - 1)) - WIDE'(1));
        min_v   = ~max_v;
        wrapped = (full <<< sh) >>> sh;
        r.ovf   = (full > max_v) || (full < min_v);
        if (sat && (full > max_v)) begin
            r.sum = max_v;
        end else if (sat && (full < min_v)) begin
            r.sum = min_v;
        end else begin
            r.sum = wrapped;
        end
        return r;
    endfunction

endpackage

// File: rtl/neuron_mult.sv
// Stage 1: registered unsigned-pixel x signed-weight product with a valid flag.
module neuron_mult
    import neuron_pkg::*;
#(
    parameter int unsigned X_WIDTH = X_WIDTH_DEF,
    parameter int unsigned W_WIDTH = W_WIDTH_DEF
) (
    input  logic                              Clk,
    input  logic                              RST,
    input  logic                              en,
    input  logic        [X_WIDTH-1:0]         x_in,
    input  logic signed [W_WIDTH-1:0]         w_in,
    output logic signed [X_WIDTH+W_WIDTH:0]   prod,
    output logic                              prod_valid
);

    localparam int unsigned P_WIDTH = X_WIDTH + W_WIDTH + 1;

    always_ff @(posedge Clk or posedge RST) begin
        if (RST) begin
            prod       <= '0;
            prod_valid <= 1'b0;
        end else begin
            prod_valid <= en;
            if (en) begin
                prod <= P_WIDTH'($signed({1'b0, x_in})) * P_WIDTH'(w_in);
            end
        end
    end

endmodule

// File: rtl/neuron_mac.sv
// Single-neuron MAC: streamed dot product plus bias with a one-cycle classify strobe.
// Define NEURON_SAT_EN to clamp on overflow; otherwise adds wrap. overflow is flagged either way.
module neuron_mac
    import neuron_pkg::*;
#(
    parameter int unsigned N_INPUTS  = N_INPUTS_DEF,
    parameter int unsigned X_WIDTH   = X_WIDTH_DEF,
    parameter int unsigned W_WIDTH   = W_WIDTH_DEF,
    parameter int unsigned ACC_WIDTH = ACC_WIDTH_DEF
) (
    input  logic                        Clk,
    input  logic                        RST,
    input  logic                        start,
    input  logic signed [W_WIDTH-1:0]   bias,
    input  logic                        x_valid,
    input  logic        [X_WIDTH-1:0]   x_in,
    input  logic signed [W_WIDTH-1:0]   w_in,
    output logic                        x_ready,
    output logic                        busy,
    output logic signed [ACC_WIDTH-1:0] Z,
    output logic                        classify,
    output logic                        overflow
);

    localparam int unsigned CNT_W   = (N_INPUTS > 1) ? $clog2(N_INPUTS) : 1;
    localparam int unsigned P_WIDTH = X_WIDTH + W_WIDTH + 1;
`ifdef NEURON_SAT_EN
    localparam logic SAT_EN = 1'b1;
`else
    localparam logic SAT_EN = 1'b0;
`endif

    state_t                      state, state_next;
    logic        [CNT_W-1:0]     cnt;
    logic signed [ACC_WIDTH-1:0] acc;
    logic signed [W_WIDTH-1:0]   bias_q;
    logic signed [P_WIDTH-1:0]   prod;
    logic                        prod_valid;
    logic                        load_c, accept_c, last_c;
    add_res_t                    acc_res, bias_res;
    logic                        unused_hi;

    neuron_mult #(.X_WIDTH(X_WIDTH), .W_WIDTH(W_WIDTH)) u_mult (
        .Clk        (Clk),
        .RST        (RST),
        .en         (accept_c),
        .x_in       (x_in),
        .w_in       (w_in),
        .prod       (prod),
        .prod_valid (prod_valid)
    );

    always_ff @(posedge Clk or posedge RST) begin
        if (RST) state <= IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (load_c) state_next = ACCUM;
            ACCUM:   if (last_c) state_next = DRAIN;
            DRAIN:   state_next = BIAS;
            BIAS:    state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Decoded control; x_ready is registered from state_next so it equals (state == ACCUM)
    always_comb begin
        load_c   = 1'b0;
        accept_c = 1'b0;
        last_c   = 1'b0;
        load_c   = (state == IDLE) && start;
        accept_c = x_valid && x_ready;
        last_c   = accept_c && (cnt == CNT_W'(N_INPUTS - 1));
    end

    always_comb begin
        acc_res  = sat_add(WIDE'(acc), WIDE'(prod), ACC_WIDTH, SAT_EN);
        bias_res = sat_add(WIDE'(acc), WIDE'(bias_q), ACC_WIDTH, SAT_EN);
    end

    assign unused_hi = ^{acc_res.sum[WIDE-1:ACC_WIDTH], bias_res.sum[WIDE-1:ACC_WIDTH]};

    always_ff @(posedge Clk or posedge RST) begin
        if (RST) begin
            cnt      <= '0;
            acc      <= '0;
            bias_q   <= '0;
            Z        <= '0;
            overflow <= 1'b0;
        end else if (load_c) begin
            cnt      <= '0;
            acc      <= '0;
            bias_q   <= bias;
            overflow <= 1'b0;
        end else begin
            if (accept_c) cnt <= cnt + CNT_W'(1);
            if (prod_valid) begin
                acc <= acc_res.sum[ACC_WIDTH-1:0];
                if (acc_res.ovf) overflow <= 1'b1;
            end
            if (state == BIAS) begin
                Z <= bias_res.sum[ACC_WIDTH-1:0];
                if (bias_res.ovf) overflow <= 1'b1;
            end
        end
    end

    always_ff @(posedge Clk or posedge RST) begin
        if (RST) begin
            x_ready  <= 1'b0;
            busy     <= 1'b0;
            classify <= 1'b0;
        end else begin
            x_ready  <= (state_next == ACCUM);
            busy     <= (state_next != IDLE);
            classify <= (state_next == DONE);
        end
    end

endmodule
